// File: rtl/nonce_replay_guard_pkg.sv
// Shared constants for the nonce replay guard:
// register offsets, bit indices and FSM encoding.
package nonce_replay_guard_pkg;

  localparam logic [3:0] ADDR_CHECK      = 4'h0;
  localparam logic [3:0] ADDR_CTRL       = 4'h4;
  localparam logic [3:0] ADDR_STATUS     = 4'h8;
  localparam logic [3:0] ADDR_REPLAY_CNT = 4'hC;

  localparam int CTRL_CLEAR     = 0;
  localparam int CTRL_INSERT_EN = 1;

  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_REPLAY   = 2;
  localparam int ST_ZERO     = 3;
  localparam int ST_OVERRUN  = 4;
  localparam int ST_FILL_LSB = 8;

  localparam logic [31:0] ZERO_NONCE = 32'h0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_COMMIT
  } state_e;

endpackage

// File: rtl/nonce_history_buf.sv
// Circular history of accepted nonces.
// Read index is relative to the oldest stored entry.
module nonce_history_buf #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_we,
  input  logic [31:0]              i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
  output logic [31:0]              o_rd_data,
  output logic [$clog2(DEPTH):0]   o_fill,
  output logic                     o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_fill;
  logic [AW-1:0] w_phys;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
    end else if (i_we) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (!o_full) r_fill <= r_fill + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Oldest entry sits at wr_ptr - fill; when full the low bits of fill are 0.
  assign w_phys    = r_wr_ptr - r_fill[AW-1:0] + i_rd_idx;
  assign o_rd_data = r_mem[w_phys];
  assign o_fill    = r_fill;
  assign o_full    = (r_fill == (AW+1)'(DEPTH));

endmodule

// File: rtl/nonce_replay_guard.sv
// Receive-side nonce replay guard: scans the history one entry
// per cycle, flags replays and stores fresh nonces.
module nonce_replay_guard
  import nonce_replay_guard_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        replay_alert,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           r_state;
  state_e           w_next;
  logic [AW-1:0]    r_idx;
  logic             r_match;
  logic [31:0]      r_last_nonce;
  logic             r_done;
  logic             r_replay;
  logic             r_zero_rej;
  logic             r_overrun;
  logic             r_ins_en;
  logic [CNT_W-1:0] r_cnt;
  logic             r_alert;

  logic             w_wr_check;
  logic             w_wr_ctrl;
  logic             w_clear;
  logic             w_cnt_clr;
  logic             w_commit;
  logic             w_hit;
  logic             w_scan_last;
  logic             w_hist_we;
  logic [31:0]      w_rd_data;
  logic [AW:0]      w_fill;
  logic             w_full;
  logic [7:0]       w_fill8;

  nonce_history_buf #(.DEPTH(DEPTH)) u_hist (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_clear),
    .i_we      (w_hist_we),
    .i_wdata   (r_last_nonce),
    .i_rd_idx  (r_idx),
    .o_rd_data (w_rd_data),
    .o_fill    (w_fill),
    .o_full    (w_full)
  );

  assign w_wr_check  = we && (addr == ADDR_CHECK);
  assign w_wr_ctrl   = we && (addr == ADDR_CTRL);
  assign w_clear     = w_wr_ctrl && wdata[CTRL_CLEAR];
  assign w_cnt_clr   = we && (addr == ADDR_REPLAY_CNT);
  assign w_commit    = (r_state == S_COMMIT) && !w_clear;
  assign w_hit       = (w_rd_data == r_last_nonce);
  assign w_scan_last = (({1'b0, r_idx} + 1'b1) == w_fill);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_clear) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (w_wr_check && (wdata != ZERO_NONCE))
            w_next = (w_fill == '0) ? S_COMMIT : S_SCAN;
        S_SCAN:
          if (w_hit || w_scan_last) w_next = S_COMMIT;
        S_COMMIT: w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    w_hist_we = w_commit && !r_match && r_ins_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_match <= 1'b0;
    end else if (w_clear || (r_state != S_SCAN)) begin
      r_idx   <= '0;
      r_match <= (r_state == S_COMMIT) && !w_clear && r_match;
    end else if (w_hit) begin
      r_match <= 1'b1;
    end else if (!w_scan_last) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_nonce <= '0;
      r_done       <= 1'b0;
      r_replay     <= 1'b0;
      r_zero_rej   <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_clear) begin
      r_done       <= 1'b0;
      r_replay     <= 1'b0;
      r_zero_rej   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_wr_check && !busy) begin
        r_last_nonce <= wdata;
        r_replay     <= 1'b0;
        r_zero_rej   <= (wdata == ZERO_NONCE);
        r_done       <= (wdata == ZERO_NONCE);
      end else if (w_wr_check) begin
        r_overrun    <= 1'b1;
      end
      if (w_commit) begin
        r_done <= 1'b1;
        if (r_match) r_replay <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ins_en <= 1'b1;
      r_cnt    <= '0;
      r_alert  <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_ins_en <= wdata[CTRL_INSERT_EN];
      // A counter clear beats a same-cycle increment.
      if (w_cnt_clr)
        r_cnt <= '0;
      else if (w_commit && r_match && (r_cnt != CNT_MAX))
        r_cnt <= r_cnt + 1'b1;
      r_alert <= w_commit && r_match;
    end
  end

  assign replay_alert = r_alert;
  assign w_fill8 = (w_full && (DEPTH > 255)) ? 8'hFF : 8'(w_fill);

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (addr == ADDR_CHECK):  rdata = r_last_nonce;
      (addr == ADDR_STATUS): begin
        rdata[ST_BUSY]             = busy;
        rdata[ST_DONE]             = r_done;
        rdata[ST_REPLAY]           = r_replay;
        rdata[ST_ZERO]             = r_zero_rej;
        rdata[ST_OVERRUN]          = r_overrun;
        rdata[ST_FILL_LSB +: 8]    = w_fill8;
      end
      (addr == ADDR_REPLAY_CNT): rdata = 32'(r_cnt);
      default: rdata = '0;
    endcase
  end

endmodule

// File: doc/nonce_replay_guard.md
Name: nonce_replay_guard

Overview:
- Receive-side counterpart to the nonce generator; authenticated message handlers use it to reject replayed nonces.
- CPU writes a received nonce. The block scans a circular history of the last DEPTH accepted nonces, one entry per cycle.
- It reports fresh or replay. Fresh nonces are inserted into the history. Every replay raises a hardware alert pulse for the security monitor.
- Sits on the same memory-mapped peripheral bus as the generator.

Parameters:
- DEPTH, 16, history entries; power of two, 2..256.
- CNT_W, 16, width of the saturating replay counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  4  register byte offset (0x0/0x4/0x8/0xC).
- we  in  1  write strobe, one cycle per write.
- wdata  in  32  write data.
- rdata  out  32  combinational read data.
- replay_alert  out  1  registered one-cycle pulse per detected replay.
- busy  out  1  high while a check is in progress.

Behaviour:
- Reset is asynchronous, active-low, single clock clk. On reset:
  - history empty; fill=0, wr_ptr=0;
  - FSM in IDLE; all status bits 0; replay_cnt=0;
  - last_nonce=0; replay_alert=0; busy=0.
- Register map:
  - 0x0 CHECK: write starts a check of wdata. Read returns last_nonce.
  - 0x4 CTRL, write only:
    - bit0 CLEAR: empties the history and aborts any check.
    - bit1 INSERT_EN: defaults to 1 after reset; when 0, fresh nonces are not stored.
  - 0x8 STATUS, read only:
    - bit0 busy, bit1 done, bit2 replay, bit3 zero_reject, bit4 overrun;
    - bits[15:8] fill, zero-extended;
    - all other bits 0.
  - 0xC REPLAY_CNT: read returns the count zero-extended; any write clears it.
  - Other offsets read 0.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE, on a write to CHECK:
  - latch last_nonce=wdata; clear done, replay, zero_reject.
  - If wdata==0: set zero_reject and done; no scan, no insert, no alert; stay IDLE.
  - Else if fill==0: go to COMMIT with match=0.
  - Else: go to SCAN with idx=0.
- SCAN, one entry per cycle:
  - Compare history[idx] with last_nonce. Entries are indexed oldest-first relative to wr_ptr; order is irrelevant to the result.
  - On match: go to COMMIT with match=1.
  - No match and idx==fill-1: go to COMMIT with match=0.
  - Otherwise idx++.
- COMMIT, one cycle:
  - match=1: set replay; replay_cnt += 1, saturating at 2^CNT_W-1; pulse replay_alert on the next cycle.
  - match=0 and INSERT_EN: write the entry at wr_ptr; wr_ptr = (wr_ptr+1) mod DEPTH; fill = min(fill+1, DEPTH). When full, the oldest entry is overwritten.
  - Set done; return to IDLE.
- Latency: from the CHECK write edge, busy is high for k SCAN cycles plus 1 COMMIT cycle. k = fill if no match, or match index + 1. Worst case is DEPTH+1 cycles. done is visible the cycle after COMMIT.
- busy = (state != IDLE). The busy port and STATUS.bit0 are identical.
- A CHECK write while busy is ignored and sets sticky overrun. Overrun is cleared only by CLEAR or reset.
- CLEAR:
  - takes priority over an in-flight scan and any same-cycle event;
  - sets fill=0, wr_ptr=0; clears done, replay, zero_reject, overrun; returns to IDLE;
  - leaves replay_cnt unchanged; produces no alert.
- A REPLAY_CNT clear in the same cycle as a COMMIT increment: the clear wins, count=0.
- A CTRL write while busy may change INSERT_EN. The value sampled in COMMIT applies.

Decomposition:
- Shared security package holds:
  - register offsets ADDR_CHECK, ADDR_CTRL, ADDR_STATUS, ADDR_REPLAY_CNT;
  - CTRL and STATUS bit indices;
  - FSM state encoding;
  - the zero-nonce constant.
- One sub-module, nonce_history_buf:
  - DEPTH x 32 storage with wr_ptr and fill;
  - write port, clear input, one indexed read port (index relative to the oldest entry);
  - fill and full outputs.
- FSM, status, counter and bus decode stay in nonce_replay_guard.

Test Plan:
- Empty history, write CHECK 0x12345678:
  - busy high exactly 1 cycle (COMMIT only);
  - then STATUS done=1, replay=0, fill=1; no alert.
- Insert 0xA, 0xB, 0xC, then CHECK 0xB:
  - busy for 2 SCAN + 1 COMMIT cycles;
  - replay=1, replay_alert single pulse, REPLAY_CNT=1, fill stays 3.
- DEPTH=4: insert 1,2,3,4,5; CHECK 1 -> fresh (evicted); CHECK 5 -> replay; fill=4.
- CHECK 0x00000000 -> zero_reject=1, done=1, no busy cycle, fill unchanged, REPLAY_CNT unchanged.
- During a scan with fill=8:
  - CHECK write -> overrun=1, last_nonce unchanged;
  - then CLEAR mid-scan -> IDLE next cycle, fill=0, busy=0, no insert, no alert.
- CNT_W=2: four replays -> REPLAY_CNT saturates at 3. Write 0xC -> 0.
